// File: rtl/dmem_responder_if.sv
// dmem_responder_if
//   CPU data-memory bus between a core (master) and dmem_responder (slave).
//   Signals:
//     d_mem_addr  [31:0]  byte address from the CPU
//     d_mem_wdata [31:0]  store data, lane i = bits 8i+7:8i
//     d_mem_wen   [3:0]   byte-lane write enables, 4'b0000 = read/idle
//     d_mem_rdata [31:0]  combinational read data back to the CPU
interface dmem_responder_if;
    logic [31:0] d_mem_addr;
    logic [31:0] d_mem_wdata;
    logic [3:0]  d_mem_wen;
    logic [31:0] d_mem_rdata;

    modport master (
        output d_mem_addr,
        output d_mem_wdata,
        output d_mem_wen,
        input  d_mem_rdata
    );

    modport slave (
        input  d_mem_addr,
        input  d_mem_wdata,
        input  d_mem_wen,
        output d_mem_rdata
    );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder
//   Data-memory responder for a CPU core: word RAM with byte-lane writes and
//   zero-latency reads, plus a small MMIO window:
//     MMIO_BASE+0  CYCLE   free-running 32-bit cycle counter (read only)
//     MMIO_BASE+4  TOHOST  full-word write loads tohost_val and sets done
//     MMIO_BASE+8  LOG     full-word write pushes into the log FIFO,
//                          read returns the FIFO occupancy
//   Ports:
//     clk, rst_n       clock, asynchronous active-low reset
//     bus              dmem_responder_if.slave CPU bus
//     done             set by a TOHOST write, held until reset
//     tohost_val       last value written to TOHOST
//     log_valid        log FIFO not empty
//     log_data         log FIFO head (0 when empty)
//     log_ready        drain side accepts the head word
//     err_misaligned   sticky: misaligned or wrong-width access seen
//     log_overflow     sticky: a log push was dropped because FIFO was full
module dmem_responder #(
    parameter int unsigned MEM_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE = 32'h0000_1000,
    parameter int unsigned LOG_DEPTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    dmem_responder_if.slave     bus,
    output logic                done,
    output logic [31:0]         tohost_val,
    output logic                log_valid,
    output logic [31:0]         log_data,
    input  logic                log_ready,
    output logic                err_misaligned,
    output logic                log_overflow
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int PW = $clog2(LOG_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [31:0]   RAM_BYTES   = 32'(4 * MEM_WORDS);
    localparam logic [31:0]   CYCLE_ADDR  = MMIO_BASE;
    localparam logic [31:0]   TOHOST_ADDR = MMIO_BASE + 32'd4;
    localparam logic [31:0]   LOG_ADDR    = MMIO_BASE + 32'd8;
    localparam logic [CW-1:0] DEPTH_C     = CW'(LOG_DEPTH);

    // ------------------------------------------------------------------
    // Address decode and write classification
    // ------------------------------------------------------------------
    logic          is_ram;
    logic          is_cycle;
    logic          is_tohost;
    logic          is_log;
    logic          is_mmio;
    logic [AW-1:0] ram_idx;
    logic          wr_any;
    logic          aligned;
    logic          full_word;
    logic          bad_access;
    logic          ram_we;
    logic          mmio_we;
    logic          tohost_we;
    logic          push_req;

    assign is_ram     = bus.d_mem_addr < RAM_BYTES;
    assign is_cycle   = bus.d_mem_addr == CYCLE_ADDR;
    assign is_tohost  = bus.d_mem_addr == TOHOST_ADDR;
    assign is_log     = bus.d_mem_addr == LOG_ADDR;
    assign is_mmio    = is_cycle | is_tohost | is_log;
    assign ram_idx    = bus.d_mem_addr[AW+1:2];

    assign wr_any     = |bus.d_mem_wen;
    assign aligned    = bus.d_mem_addr[1:0] == 2'b00;
    assign full_word  = &bus.d_mem_wen;

    // Misalignment is flagged for any target, mapped or not; a partial
    // write into the MMIO window is flagged as an illegal width.
    assign bad_access = wr_any && (!aligned || (is_mmio && !full_word));

    // rst_n gates the enables so a write presented during reset (including
    // on the edge where reset is asserted) never reaches storage.
    assign ram_we     = rst_n && wr_any && aligned && is_ram;
    assign mmio_we    = rst_n && wr_any && aligned && full_word;
    assign tohost_we  = mmio_we && is_tohost;
    assign push_req   = mmio_we && is_log;

    // ------------------------------------------------------------------
    // RAM: one byte-wide array per lane so each lane has its own write
    // enable; reads are asynchronous to give zero-latency load data.
    // Contents are deliberately untouched by reset.
    // ------------------------------------------------------------------
    logic [7:0]  ram_lane_rd [4];
    logic [31:0] ram_word;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [MEM_WORDS];

            always_ff @(posedge clk) begin
                if (ram_we && bus.d_mem_wen[gi]) begin
                    lane_mem[ram_idx] <= bus.d_mem_wdata[8*gi +: 8];
                end
            end

            assign ram_lane_rd[gi] = lane_mem[ram_idx];
        end
    endgenerate

    assign ram_word = {ram_lane_rd[3], ram_lane_rd[2], ram_lane_rd[1], ram_lane_rd[0]};

    // ------------------------------------------------------------------
    // Log FIFO
    // ------------------------------------------------------------------
    logic [31:0]   fifo_mem [LOG_DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          fifo_full;
    logic          pop;
    logic          push;
    logic          overflow;

    assign fifo_full = count_reg == DEPTH_C;
    assign log_valid = count_reg != '0;
    // Pop only sees the registered state, so a word pushed into an empty
    // FIFO is never popped in the same cycle.
    assign pop       = log_valid && log_ready;
    // A simultaneous pop frees the slot a push into a full FIFO needs.
    assign push      = push_req && (!fifo_full || pop);
    assign overflow  = push_req && fifo_full && !pop;
    assign log_data  = log_valid ? fifo_mem[rd_ptr_reg] : 32'h0;

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= bus.d_mem_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Control and status registers
    // ------------------------------------------------------------------
    logic [31:0] cycle_reg;
    logic [31:0] tohost_reg;
    logic        done_reg;
    logic        err_reg;
    logic        ovf_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_reg  <= '0;
            tohost_reg <= '0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
            ovf_reg    <= 1'b0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            cycle_reg <= cycle_reg + 32'd1;
            if (tohost_we) begin
                tohost_reg <= bus.d_mem_wdata;
                done_reg   <= 1'b1;
            end
            if (bad_access) begin
                err_reg <= 1'b1;
            end
            if (overflow) begin
                ovf_reg <= 1'b1;
            end
            // Pointers are PW bits wide, so they wrap modulo LOG_DEPTH.
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_next;
        end
    end

    assign done           = done_reg;
    assign tohost_val     = tohost_reg;
    assign err_misaligned = err_reg;
    assign log_overflow   = ovf_reg;

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        bus.d_mem_rdata = 32'h0;
        if (is_ram) begin
            bus.d_mem_rdata = ram_word;
        end else if (is_cycle) begin
            bus.d_mem_rdata = cycle_reg;
        end else if (is_tohost) begin
            bus.d_mem_rdata = tohost_reg;
        end else if (is_log) begin
            bus.d_mem_rdata = 32'(count_reg);
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    localparam int unsigned MEM_WORDS = 1024;
    localparam logic [31:0] MMIO_BASE = 32'h0000_1000;
    localparam int unsigned DEPTH     = 8;
    localparam logic [31:0] A_CYCLE   = MMIO_BASE;
    localparam logic [31:0] A_TOHOST  = MMIO_BASE + 32'd4;
    localparam logic [31:0] A_LOG     = MMIO_BASE + 32'd8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        log_ready = 1'b0;
    logic        done;
    logic [31:0] tohost_val;
    logic        log_valid;
    logic [31:0] log_data;
    logic        err_misaligned;
    logic        log_overflow;

    dmem_responder_if bus_if ();

    dmem_responder #(
        .MEM_WORDS (MEM_WORDS),
        .MMIO_BASE (MMIO_BASE),
        .LOG_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus_if.slave),
        .done           (done),
        .tohost_val     (tohost_val),
        .log_valid      (log_valid),
        .log_data       (log_data),
        .log_ready      (log_ready),
        .err_misaligned (err_misaligned),
        .log_overflow   (log_overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural reference model
    logic [31:0] m_ram [MEM_WORDS];
    logic [31:0] m_q [$];
    logic [31:0] m_cyc;
    logic [31:0] m_tohost;
    logic        m_done;
    logic        m_err;
    logic        m_ovf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_q.delete();
        m_cyc    = '0;
        m_tohost = '0;
        m_done   = 1'b0;
        m_err    = 1'b0;
        m_ovf    = 1'b0;
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (a < 32'(4 * MEM_WORDS)) return m_ram[a >> 2];
        if (a == A_CYCLE)  return m_cyc;
        if (a == A_TOHOST) return m_tohost;
        if (a == A_LOG)    return 32'(m_q.size());
        return 32'h0;
    endfunction

    // Effect of one rising edge given the inputs currently on the bus.
    task automatic model_edge();
        logic [31:0] a;
        logic [31:0] w;
        logic [3:0]  e;
        bit          push_req;
        bit          do_pop;
        a = bus_if.d_mem_addr;
        w = bus_if.d_mem_wdata;
        e = bus_if.d_mem_wen;
        if (!rst_n) return;
        m_cyc    = m_cyc + 32'd1;
        push_req = 1'b0;
        if (e != 4'h0) begin
            if (a[1:0] != 2'b00) begin
                m_err = 1'b1;
            end else if (a < 32'(4 * MEM_WORDS)) begin
                for (int l = 0; l < 4; l++) begin
                    if (e[l]) m_ram[a >> 2][8*l +: 8] = w[8*l +: 8];
                end
            end else if (a == A_CYCLE || a == A_TOHOST || a == A_LOG) begin
                if (e != 4'hF) begin
                    m_err = 1'b1;
                end else if (a == A_TOHOST) begin
                    m_tohost = w;
                    m_done   = 1'b1;
                end else if (a == A_LOG) begin
                    push_req = 1'b1;
                end
            end
        end
        do_pop = (m_q.size() != 0) && log_ready;
        if (do_pop) void'(m_q.pop_front());
        if (push_req) begin
            if (m_q.size() < DEPTH) m_q.push_back(w);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] w, input logic [3:0] e);
        bus_if.d_mem_addr  = a;
        bus_if.d_mem_wdata = w;
        bus_if.d_mem_wen   = e;
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_done"}, 32'(done), 32'(m_done));
        chk({tag, "_tohost"}, tohost_val, m_tohost);
        chk({tag, "_err"}, 32'(err_misaligned), 32'(m_err));
        chk({tag, "_ovf"}, 32'(log_overflow), 32'(m_ovf));
        chk({tag, "_lvalid"}, 32'(log_valid), 32'(m_q.size() != 0));
        chk({tag, "_ldata"}, log_data, (m_q.size() != 0) ? m_q[0] : 32'h0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_reset();
        log_ready = 1'b0;
        drive(32'h0, 32'h0, 4'h0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wen;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vt [9];

    initial begin
        logic [31:0] a;
        logic [31:0] w;
        logic [3:0]  e;
        int          kind;

        for (int i = 0; i < int'(MEM_WORDS); i++) m_ram[i] = '0;
        m_reset();
        drive(32'h0, 32'h0, 4'h0);

        // ---------------- reset state ----------------
        do_reset();
        check_state("reset");
        drive(A_CYCLE, 32'h0, 4'h0);
        #1;
        chk("reset_cycle", bus_if.d_mem_rdata, 32'h0);

        // ---------------- table-driven vectors ----------------
        vt[0] = '{32'h0000_0200, 32'h0000_0037, 4'b1111, 32'h0000_0037, 1'b0};
        vt[1] = '{32'h0000_0200, 32'h0000_AB00, 4'b0010, 32'h0000_AB37, 1'b0};
        vt[2] = '{32'h0000_0204, 32'h1122_3344, 4'b1111, 32'h1122_3344, 1'b0};
        vt[3] = '{32'h0000_0204, 32'hAABB_CCDD, 4'b0101, 32'h11BB_33DD, 1'b0};
        vt[4] = '{32'h0000_0FFC, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, 1'b0};
        vt[5] = '{32'h0000_5000, 32'h1234_5678, 4'b1111, 32'h0000_0000, 1'b0};
        vt[6] = '{MMIO_BASE + 32'd12, 32'h1, 4'b1111, 32'h0000_0000, 1'b0};
        vt[7] = '{A_TOHOST, 32'h0000_0055, 4'b1111, 32'h0000_0055, 1'b0};
        vt[8] = '{A_TOHOST, 32'h0000_0099, 4'b0011, 32'h0000_0055, 1'b1};

        for (int i = 0; i < 9; i++) begin
            drive(vt[i].addr, vt[i].wdata, vt[i].wen);
            tick();
            drive(vt[i].addr, 32'h0, 4'h0);
            #1;
            $display("vec %0d addr=%h wen=%b wdata=%h rdata=%h err=%b",
                     i, vt[i].addr, vt[i].wen, vt[i].wdata, bus_if.d_mem_rdata, err_misaligned);
            chk("tbl_rdata", bus_if.d_mem_rdata, vt[i].exp_rd);
            chk("tbl_err", 32'(err_misaligned), 32'(vt[i].exp_err));
        end
        check_state("tbl_end");

        // ---------------- misaligned write ----------------
        do_reset();
        drive(32'h0000_0202, 32'hFFFF_FFFF, 4'hF);
        #1;
        chk("mis_err_before", 32'(err_misaligned), 32'h0);
        tick();
        drive(32'h0000_0200, 32'h0, 4'h0);
        #1;
        $display("misaligned write 0x202 rdata@0x200=%h err=%b", bus_if.d_mem_rdata, err_misaligned);
        chk("mis_ram", bus_if.d_mem_rdata, 32'h0000_AB37);
        chk("mis_err", 32'(err_misaligned), 32'h1);
        for (int i = 0; i < 3; i++) tick();
        chk("mis_sticky", 32'(err_misaligned), 32'h1);

        // ---------------- TOHOST and CYCLE ----------------
        do_reset();
        drive(A_TOHOST, 32'h0000_0055, 4'hF);
        #1;
        chk("tohost_done_before", 32'(done), 32'h0);
        tick();
        $display("tohost write 0x55 done=%b tohost_val=%h", done, tohost_val);
        chk("tohost_done", 32'(done), 32'h1);
        chk("tohost_val", tohost_val, 32'h0000_0055);
        drive(A_CYCLE, 32'h0, 4'h0);
        #1;
        chk("cycle_n", bus_if.d_mem_rdata, m_cyc);
        tick();
        chk("cycle_n1", bus_if.d_mem_rdata, m_cyc);
        $display("cycle read=%h", bus_if.d_mem_rdata);

        // ---------------- FIFO overflow then drain ----------------
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            drive(A_LOG, 32'(i), 4'hF);
            tick();
            $display("log push %0d count_valid=%b ovf=%b", i, log_valid, log_overflow);
        end
        drive(A_LOG, 32'h0, 4'h0);
        #1;
        chk("log_count_full", bus_if.d_mem_rdata, 32'd8);
        chk("log_ovf", 32'(log_overflow), 32'h1);
        log_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk("drain_valid", 32'(log_valid), 32'h1);
            chk("drain_data", log_data, 32'(i));
            $display("log pop data=%h", log_data);
            tick();
        end
        chk("drain_empty_valid", 32'(log_valid), 32'h0);
        chk("drain_empty_data", log_data, 32'h0);
        tick();
        chk("drain_empty_count", bus_if.d_mem_rdata, 32'h0);

        // ---------------- full & push & pop ----------------
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            drive(A_LOG, 32'h100 + 32'(i), 4'hF);
            tick();
        end
        log_ready = 1'b1;
        drive(A_LOG, 32'h0000_0777, 4'hF);
        tick();
        drive(A_LOG, 32'h0, 4'h0);
        log_ready = 1'b0;
        #1;
        $display("full push+pop count=%0d ovf=%b head=%h", bus_if.d_mem_rdata, log_overflow, log_data);
        chk("fullpp_count", bus_if.d_mem_rdata, 32'd8);
        chk("fullpp_ovf", 32'(log_overflow), 32'h0);
        chk("fullpp_head", log_data, 32'h0000_0102);
        check_state("fullpp");

        // ---------------- empty & push & ready ----------------
        do_reset();
        log_ready = 1'b1;
        drive(A_LOG, 32'h0000_0ABC, 4'hF);
        tick();
        drive(A_LOG, 32'h0, 4'h0);
        log_ready = 1'b0;
        #1;
        $display("empty push+ready valid=%b data=%h", log_valid, log_data);
        chk("nofall_valid", 32'(log_valid), 32'h1);
        chk("nofall_data", log_data, 32'h0000_0ABC);
        chk("nofall_count", bus_if.d_mem_rdata, 32'd1);

        // ---------------- reset mid-operation ----------------
        do_reset();
        drive(32'h0000_0200, 32'hDEAD_BEEF, 4'hF);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(A_LOG, 32'h10 + 32'(i), 4'hF);
            tick();
        end
        drive(A_TOHOST, 32'h1, 4'hF);
        tick();
        drive(A_LOG, 32'h0, 4'h0);
        #1;
        chk("pre_rst_count", bus_if.d_mem_rdata, 32'd3);
        chk("pre_rst_done", 32'(done), 32'h1);
        #1;
        rst_n = 1'b0;
        m_reset();
        #1;
        $display("mid reset valid=%b done=%b", log_valid, done);
        chk("rst_valid", 32'(log_valid), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        drive(A_CYCLE, 32'h0, 4'h0);
        #1;
        chk("rst_cycle", bus_if.d_mem_rdata, 32'h0);
        drive(32'h0000_0200, 32'h0, 4'h0);
        #1;
        chk("rst_ram", bus_if.d_mem_rdata, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_state("post_rst");

        // ---------------- randomized against model ----------------
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(32'(i * 4), $urandom, 4'hF);
            tick();
        end
        for (int t = 0; t < 300; t++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 5) begin
                a = 32'($urandom_range(0, 15) * 4);
                if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(0, 3));
            end else if (kind == 6) begin
                a = A_TOHOST;
            end else if (kind <= 8) begin
                a = A_LOG;
            end else begin
                a = ($urandom_range(0, 1) == 0) ? A_CYCLE : 32'h0000_2000 + 32'($urandom_range(0, 255));
            end
            case ($urandom_range(0, 4))
                0, 1:    e = 4'h0;
                2, 3:    e = 4'hF;
                default: e = 4'($urandom_range(0, 15));
            endcase
            w = $urandom;
            log_ready = 1'($urandom_range(0, 1));
            drive(a, w, e);
            #1;
            $display("txn %0d addr=%h wen=%b wdata=%h ready=%b rdata=%h",
                     t, a, e, w, log_ready, bus_if.d_mem_rdata);
            chk("rnd_rdata", bus_if.d_mem_rdata, m_read(a));
            check_state("rnd");
            tick();
        end
        drive(32'h0, 32'h0, 4'h0);
        #1;
        check_state("rnd_end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024: RAM depth in 32-bit words, byte range 0 .. 4*MEM_WORDS-1.
REQ-002 SHALL have parameter MMIO_BASE, default 32'h0000_1000: base of the MMIO window (3 registers); MMIO_BASE >= 4*MEM_WORDS.
REQ-003 SHALL have parameter LOG_DEPTH, default 8: log FIFO depth, power of two.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 d_mem_addr  input  32  byte address from CPU.
REQ-007 d_mem_wdata  input  32  store data, lane i = bits 8i+7:8i.
REQ-008 d_mem_wen  input  4  byte-lane write enables; 4'b0000 = read/idle.
REQ-009 d_mem_rdata  output  32  read data, combinational from d_mem_addr.
REQ-010 done  output  1  set by a write to TOHOST.
REQ-011 tohost_val  output  32  last value written to TOHOST.
REQ-012 log_valid  output  1  log FIFO not empty.
REQ-013 log_data  output  32  log FIFO head word; 0 when empty.
REQ-014 log_ready  input  1  drain side accepts head when log_valid & log_ready.
REQ-015 err_misaligned  output  1  sticky: misaligned or illegal-width access seen.
REQ-016 log_overflow  output  1  sticky: log push dropped because FIFO full.

Function
REQ-017 SHALL decode: RAM = addr < 4*MEM_WORDS; CYCLE = MMIO_BASE+0 (RO); TOHOST = MMIO_BASE+4 (RW); LOG = MMIO_BASE+8 (W push, R = occupancy count zero-extended); anything else unmapped.
REQ-018 RAM read SHALL return mem[addr[31:2]] in the same cycle (zero latency); addr[1:0] ignored on reads.
REQ-019 RAM write SHALL occur on the clock edge, updating only lanes whose d_mem_wen bit is 1.
REQ-020 Any write with addr[1:0] != 0 SHALL be dropped and set err_misaligned.
REQ-021 MMIO writes SHALL take effect only with d_mem_wen == 4'b1111; any other nonzero wen to MMIO SHALL be dropped and set err_misaligned.
REQ-022 Unmapped reads SHALL return 32'h0; unmapped writes SHALL be dropped silently.
REQ-023 CYCLE SHALL be a 32-bit counter, 0 at reset, +1 every clock while rst_n=1, wrapping FFFF_FFFF -> 0; writes ignored.
REQ-024 A full-word write to TOHOST SHALL load tohost_val and set done the next cycle; done stays 1 until reset; later writes update tohost_val.
REQ-025 A full-word write to LOG SHALL push d_mem_wdata; pop occurs when log_valid & log_ready.
REQ-026 FIFO full & push & no pop: push dropped, log_overflow set; full & push & pop in same cycle: both occur, count unchanged, no overflow.
REQ-027 Empty & pop request: no action, count stays 0; empty & push & log_ready: word pushed, not popped that cycle (no fall-through).
REQ-028 FIFO pointers SHALL wrap modulo LOG_DEPTH; occupancy range 0..LOG_DEPTH.
REQ-029 Writes SHALL be ignored while rst_n=0.

Reset
REQ-030 On rst_n=0, asynchronously: done=0, tohost_val=0, CYCLE=0, FIFO empty (log_valid=0, log_data=0), err_misaligned=0, log_overflow=0.
REQ-031 RAM contents SHALL NOT be affected by reset; array is zero at time 0; reset mid-operation discards FIFO contents and any in-flight write on that edge.

Verification
REQ-032 SW 0x200=0x0000_0037, read 0x200 -> 0x37; then wen=4'b0010 wdata=0x0000_AB00 at 0x200 -> read 0x0000_AB37.
REQ-033 Write wen=4'b1111 at 0x202 -> RAM unchanged, err_misaligned=1 next cycle, stays 1 until reset.
REQ-034 Push 9 words 1..9 to LOG with log_ready=0 (depth 8) -> LOG read = 8, log_overflow=1; raise log_ready -> log_data sequence 1..8, then log_valid=0.
REQ-035 Write 0x55 to TOHOST -> done=1 and tohost_val=0x55 next cycle; CYCLE read N then one cycle later N+1.
REQ-036 Assert rst_n=0 mid-cycle with 3 FIFO entries and done=1 -> immediately log_valid=0, done=0, CYCLE=0; RAM word 0x200 retains prior value.
